// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: digit load handshake from the BCD converter and seven-segment pin bundle.
interface bcd_scan_display_if;
    logic       load;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic [6:0] seg;
    logic [3:0] an;
    logic       ack;
    modport master (output load, ones, tens, hundreds, thousands, input seg, an, ack);
    modport slave  (input load, ones, tens, hundreds, thousands, output seg, an, ack);
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: four-digit multiplexed common-anode seven-segment driver with frame-aligned digit swap.
// Optional BCD_SCAN_BLANK_LEADING_ZEROS_EN blanks leading zero digits (ones always shown).
module bcd_scan_display #(
    parameter int REFRESH_DIV = 50000
) (
    input logic               clock,
    input logic               resetn,
    bcd_scan_display_if.slave bus
);
    typedef enum logic [1:0] {SCAN0, SCAN1, SCAN2, SCAN3} scan_e;

    scan_e       idx_q, idx_d;
    logic [19:0] cnt_q, cnt_d;
    logic [15:0] stg_q, stg_d, disp_q, disp_d;
    logic        pend_q, pend_d, swp_q, ack_q;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d, digit, blank;
    logic [15:0] din;
    logic        tc, swap;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx_q  <= SCAN0;
            cnt_q  <= '0;
            stg_q  <= '0;
            disp_q <= '0;
            pend_q <= 1'b0;
            swp_q  <= 1'b0;
            ack_q  <= 1'b0;
            seg_q  <= 7'h7F;
            an_q   <= 4'hF;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            stg_q  <= stg_d;
            disp_q <= disp_d;
            pend_q <= pend_d;
            swp_q  <= swap;
            ack_q  <= swp_q;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    // A load landing on the swap cycle bypasses staging so the newest digits win.
    always_comb begin
        din    = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
        tc     = cnt_q == 20'(REFRESH_DIV - 1);
        cnt_d  = tc ? '0 : cnt_q + 20'd1;
        idx_d  = tc ? scan_e'(idx_q + 2'd1) : idx_q;
        swap   = tc && idx_q == SCAN3 && (pend_q || bus.load);
        stg_d  = bus.load ? din : stg_q;
        pend_d = !swap && (bus.load || pend_q);
        disp_d = swap ? (bus.load ? din : stg_q) : disp_q;
    end

    always_comb begin
        digit = disp_q[{idx_q, 2'b00} +: 4];
`ifdef BCD_SCAN_BLANK_LEADING_ZEROS_EN
        blank = {disp_q[15:12] == 4'd0, disp_q[15:8] == 8'd0, disp_q[15:4] == 12'd0, 1'b0};
`else
        blank = 4'b0000;
`endif
        an_d  = blank[idx_q] ? 4'hF : ~(4'b0001 << idx_q);
        seg_d = blank[idx_q] ? 7'h7F : glyph(digit);
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.ack = ack_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed checks of scan timing, frame-aligned swap, ack, decode and async reset.
module tb_bcd_scan_display;
`ifdef BCD_SCAN_BLANK_LEADING_ZEROS_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [6:0] G [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   k = 0;
    int   total = 0;
    int   bad = 0;

    bcd_scan_display_if bus();
    bcd_scan_display #(.REFRESH_DIV(4)) dut (.clock(clk), .resetn(resetn), .bus(bus));

    initial forever #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
        k++;
    endtask

    task automatic go(input int t);
        while (k < t) step();
    endtask

    task automatic drive(input logic l, input logic [3:0] o, input logic [3:0] t, input logic [3:0] h, input logic [3:0] th);
        bus.load = l;
        bus.ones = o;
        bus.tens = t;
        bus.hundreds = h;
        bus.thousands = th;
    endtask

    function automatic int slot(input int e);
        return ((e - 1) / 4) % 4;
    endfunction

    // expected pins for a slot while the display holds all zeros
    function automatic logic [3:0] z_an(input int s);
        return (BLANK && s != 0) ? 4'hF : ~(4'b0001 << s);
    endfunction

    function automatic logic [6:0] z_seg(input int s);
        return (BLANK && s != 0) ? 7'h7F : G[0];
    endfunction

    task automatic test_reset;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        total += 3;
        if (bus.seg !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %b want %b", bus.seg, 7'h7F); end
        if (bus.an !== 4'hF) begin bad++; $display("FAIL reset_an: got %b want %b", bus.an, 4'hF); end
        if (bus.ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        @(negedge clk);
        resetn = 1'b1;
        k = 0;
        step();
        total += 2;
        if (bus.an !== 4'b1110) begin bad++; $display("FAIL first_an: got %b want 1110", bus.an); end
        if (bus.seg !== G[0]) begin bad++; $display("FAIL first_seg: got %b want %b", bus.seg, G[0]); end
    endtask

    task automatic test_scan;
        while (k < 16) begin
            step();
            total += 3;
            if (bus.an !== z_an(slot(k))) begin bad++; $display("FAIL scan_an k=%0d: got %b want %b", k, bus.an, z_an(slot(k))); end
            if (bus.seg !== z_seg(slot(k))) begin bad++; $display("FAIL scan_seg k=%0d: got %b want %b", k, bus.seg, z_seg(slot(k))); end
            if (bus.ack !== 1'b0) begin bad++; $display("FAIL scan_ack k=%0d: got %b want 0", k, bus.ack); end
        end
    endtask

    task automatic test_load;
        go(21);
        drive(1, 1, 2, 3, 4);
        step();
        drive(0, 0, 0, 0, 0);
        while (k < 32) begin
            step();
            total++;
            if (bus.ack !== 1'b0) begin bad++; $display("FAIL load_early_ack k=%0d: got %b want 0", k, bus.ack); end
        end
        step();
        total += 3;
        if (bus.ack !== 1'b1) begin bad++; $display("FAIL load_ack: got %b want 1", bus.ack); end
        if (bus.an !== 4'b1110) begin bad++; $display("FAIL load_ack_an: got %b want 1110", bus.an); end
        if (bus.seg !== G[1]) begin bad++; $display("FAIL load_ack_seg: got %b want %b", bus.seg, G[1]); end
        step();
        total++;
        if (bus.ack !== 1'b0) begin bad++; $display("FAIL load_ack_width: got %b want 0", bus.ack); end
        for (int d = 2; d <= 4; d++) begin
            go(33 + 4 * (d - 1));
            total += 2;
            if (bus.an !== ~(4'b0001 << (d - 1))) begin bad++; $display("FAIL load_an d=%0d: got %b want %b", d, bus.an, ~(4'b0001 << (d - 1))); end
            if (bus.seg !== G[d]) begin bad++; $display("FAIL load_seg d=%0d: got %b want %b", d, bus.seg, G[d]); end
        end
    endtask

    task automatic test_double_load;
        while (k < 64) begin
            if (k == 50) drive(1, 5, 5, 5, 5);
            else if (k == 55) drive(1, 9, 8, 7, 6);
            else drive(0, 0, 0, 0, 0);
            step();
            total += 2;
            if (bus.ack !== 1'b0) begin bad++; $display("FAIL dbl_early_ack k=%0d: got %b want 0", k, bus.ack); end
            if (bus.seg === G[5]) begin bad++; $display("FAIL dbl_five k=%0d: got %b want not %b", k, bus.seg, G[5]); end
        end
        drive(0, 0, 0, 0, 0);
        step();
        total += 3;
        if (bus.ack !== 1'b1) begin bad++; $display("FAIL dbl_ack: got %b want 1", bus.ack); end
        if (bus.an !== 4'b1110) begin bad++; $display("FAIL dbl_an: got %b want 1110", bus.an); end
        if (bus.seg !== G[9]) begin bad++; $display("FAIL dbl_seg0: got %b want %b", bus.seg, G[9]); end
        while (k < 78) begin
            step();
            total += 2;
            if (bus.ack !== 1'b0) begin bad++; $display("FAIL dbl_late_ack k=%0d: got %b want 0", k, bus.ack); end
            if (bus.seg === G[5]) begin bad++; $display("FAIL dbl_five_late k=%0d: got %b want not %b", k, bus.seg, G[5]); end
            if (k == 69 || k == 73 || k == 77) begin
                total++;
                if (bus.seg !== G[8 - (k - 69) / 4]) begin bad++; $display("FAIL dbl_seg k=%0d: got %b want %b", k, bus.seg, G[8 - (k - 69) / 4]); end
            end
        end
    endtask

    task automatic test_swap_load;
        go(79);
        drive(1, 0, 0, 0, 7);
        step();
        drive(0, 0, 0, 0, 0);
        total++;
        if (bus.ack !== 1'b0) begin bad++; $display("FAIL swp_ack_early: got %b want 0", bus.ack); end
        step();
        total += 3;
        if (bus.ack !== 1'b1) begin bad++; $display("FAIL swp_ack: got %b want 1", bus.ack); end
        if (bus.an !== 4'b1110) begin bad++; $display("FAIL swp_an0: got %b want 1110", bus.an); end
        if (bus.seg !== G[0]) begin bad++; $display("FAIL swp_seg0: got %b want %b", bus.seg, G[0]); end
        while (k < 97) begin
            step();
            total++;
            if (bus.ack !== 1'b0) begin bad++; $display("FAIL swp_pending k=%0d: got %b want 0", k, bus.ack); end
            if (k == 85 || k == 89) begin
                total += 2;
                if (bus.an !== z_an(slot(k))) begin bad++; $display("FAIL swp_an k=%0d: got %b want %b", k, bus.an, z_an(slot(k))); end
                if (bus.seg !== z_seg(slot(k))) begin bad++; $display("FAIL swp_seg k=%0d: got %b want %b", k, bus.seg, z_seg(slot(k))); end
            end
            if (k == 93) begin
                total += 2;
                if (bus.an !== 4'b0111) begin bad++; $display("FAIL swp_an3: got %b want 0111", bus.an); end
                if (bus.seg !== G[7]) begin bad++; $display("FAIL swp_seg3: got %b want %b", bus.seg, G[7]); end
            end
        end
    endtask

    task automatic test_invalid;
        go(100);
        drive(1, 1, 2, 3, 4'hC);
        step();
        drive(0, 0, 0, 0, 0);
        go(113);
        total += 2;
        if (bus.ack !== 1'b1) begin bad++; $display("FAIL inv_ack: got %b want 1", bus.ack); end
        if (bus.seg !== G[1]) begin bad++; $display("FAIL inv_seg0: got %b want %b", bus.seg, G[1]); end
        go(125);
        total += 2;
        if (bus.an !== 4'b0111) begin bad++; $display("FAIL inv_an3: got %b want 0111", bus.an); end
        if (bus.seg !== 7'b0111111) begin bad++; $display("FAIL inv_dash: got %b want 0111111", bus.seg); end
    endtask

    task automatic test_async_reset;
        go(130);
        drive(1, 8, 8, 8, 8);
        step();
        drive(0, 0, 0, 0, 0);
        go(137);
        #2 resetn = 1'b0;
        #1;
        total += 3;
        if (bus.seg !== 7'h7F) begin bad++; $display("FAIL arst_seg: got %b want %b", bus.seg, 7'h7F); end
        if (bus.an !== 4'hF) begin bad++; $display("FAIL arst_an: got %b want %b", bus.an, 4'hF); end
        if (bus.ack !== 1'b0) begin bad++; $display("FAIL arst_ack: got %b want 0", bus.ack); end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        k = 0;
        while (k < 40) begin
            step();
            total += 3;
            if (bus.ack !== 1'b0) begin bad++; $display("FAIL arst_post_ack k=%0d: got %b want 0", k, bus.ack); end
            if (bus.an !== z_an(slot(k))) begin bad++; $display("FAIL arst_post_an k=%0d: got %b want %b", k, bus.an, z_an(slot(k))); end
            if (bus.seg !== z_seg(slot(k))) begin bad++; $display("FAIL arst_post_seg k=%0d: got %b want %b", k, bus.seg, z_seg(slot(k))); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_double_load();
        test_swap_load();
        test_invalid();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
